// File: rtl/axis_packet_framer_if.sv
// Word-stream bus between the serial bridge, the framer and the downstream consumer.
interface axis_packet_framer_if;
  logic        tvalid;
  logic        tready;
  logic        tlast;
  logic [31:0] tdata;
  logic [7:0]  tuser;

  modport master (output tvalid, tlast, tdata, tuser, input tready);
  modport slave  (input tvalid, tlast, tdata, output tready);
endinterface

// File: rtl/axis_packet_framer.sv
// Splits a raw word stream into packets: [31:24] opcode, [15:0] length N, then N payload words.
// Optional stall timeout with a FLUSH beat is enabled by defining AXIS_PACKET_FRAMER_TIMEOUT_EN.
module axis_packet_framer #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                 aclk,
  input  logic                 reset,
  axis_packet_framer_if.slave  s_axis,
  axis_packet_framer_if.master m_axis,
  output logic                 busy,
  output logic [7:0]           err_count
);

`ifdef AXIS_PACKET_FRAMER_TIMEOUT_EN
  typedef enum logic [1:0] {HEADER = 2'd0, PAYLOAD = 2'd1, FLUSH = 2'd2} state_t;
`else
  typedef enum logic [0:0] {HEADER = 1'b0, PAYLOAD = 1'b1} state_t;
`endif

  state_t      state, state_nxt;
  logic [7:0]  opcode;
  logic [15:0] remaining;
  logic        out_vld, out_last;
  logic [31:0] out_dat;
  logic [7:0]  out_user;
  logic        out_free;
  logic        s_rdy, hdr_ok, hdr_zero, pay_load, pay_last, err_inc;
  logic        unused_in;

  assign out_free  = !out_vld || m_axis.tready;
  assign unused_in = ^{s_axis.tlast, s_axis.tdata[23:16]};

`ifdef AXIS_PACKET_FRAMER_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [STALL_W-1:0] stall_cnt;
  logic               stall, timeout, flush_load;

  // Stall time accumulates only while the bridge offers nothing; a blocked beat just holds the count.
  assign stall   = (state == PAYLOAD) && !s_axis.tvalid;
  assign timeout = stall && (stall_cnt == STALL_W'(TIMEOUT_CYCLES - 1));
  assign err_inc = hdr_zero || timeout;

  always_ff @(posedge aclk or posedge reset) begin
    if (reset)
      stall_cnt <= '0;
    else if (state != PAYLOAD || pay_load || timeout)
      stall_cnt <= '0;
    else if (stall)
      stall_cnt <= stall_cnt + STALL_W'(1);
  end
`else
  logic [31:0] unused_timeout_cfg;
  assign unused_timeout_cfg = 32'(TIMEOUT_CYCLES);
  assign err_inc = hdr_zero;
`endif

  always_ff @(posedge aclk or posedge reset) begin
    if (reset) state <= HEADER;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      HEADER:  if (hdr_ok) state_nxt = PAYLOAD;
      PAYLOAD: begin
        if (pay_last) state_nxt = HEADER;
`ifdef AXIS_PACKET_FRAMER_TIMEOUT_EN
        else if (timeout) state_nxt = FLUSH;
`endif
      end
`ifdef AXIS_PACKET_FRAMER_TIMEOUT_EN
      FLUSH:   if (flush_load) state_nxt = HEADER;
`endif
      default: state_nxt = HEADER;
    endcase
  end

  // Headers are taken regardless of the output register, so a pending last beat never blocks parsing.
  always_comb begin
    s_rdy    = 1'b0;
    hdr_ok   = 1'b0;
    hdr_zero = 1'b0;
    pay_load = 1'b0;
    pay_last = 1'b0;
`ifdef AXIS_PACKET_FRAMER_TIMEOUT_EN
    flush_load = 1'b0;
`endif
    case (state)
      HEADER: begin
        s_rdy    = !reset;
        hdr_ok   = s_axis.tvalid && !reset && (s_axis.tdata[15:0] != 16'd0);
        hdr_zero = s_axis.tvalid && !reset && (s_axis.tdata[15:0] == 16'd0);
      end
      PAYLOAD: begin
        s_rdy    = out_free;
        pay_load = s_axis.tvalid && out_free;
        pay_last = pay_load && (remaining == 16'd1);
      end
`ifdef AXIS_PACKET_FRAMER_TIMEOUT_EN
      FLUSH: flush_load = out_free;
`endif
      default: s_rdy = 1'b0;
    endcase
  end

  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      opcode    <= 8'd0;
      remaining <= 16'd0;
      out_vld   <= 1'b0;
      out_last  <= 1'b0;
      out_dat   <= 32'd0;
      out_user  <= 8'd0;
      err_count <= 8'd0;
    end else begin
      if (hdr_ok) begin
        opcode    <= s_axis.tdata[31:24];
        remaining <= s_axis.tdata[15:0];
      end else if (pay_load) begin
        remaining <= remaining - 16'd1;
      end

      if (pay_load) begin
        out_vld  <= 1'b1;
        out_dat  <= s_axis.tdata;
        out_last <= pay_last;
        out_user <= opcode;
      end
`ifdef AXIS_PACKET_FRAMER_TIMEOUT_EN
      else if (flush_load) begin
        out_vld  <= 1'b1;
        out_dat  <= 32'd0;
        out_last <= 1'b1;
        out_user <= opcode;
      end
`endif
      else if (m_axis.tready) begin
        out_vld <= 1'b0;
      end

      if (err_inc && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

  assign s_axis.tready = s_rdy;
  assign m_axis.tvalid = out_vld;
  assign m_axis.tlast  = out_last;
  assign m_axis.tdata  = out_dat;
  assign m_axis.tuser  = out_user;
  assign busy          = (state != HEADER);

endmodule

// File: tb/tb_axis_packet_framer.sv
// Bench for axis_packet_framer: cycle table, hand-written corner sequences, randomized packets vs. a parser model.
`timescale 1ns/1ps
module tb_axis_packet_framer;
`ifdef AXIS_PACKET_FRAMER_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 4096;
`endif

  logic       aclk = 1'b0;
  logic       reset = 1'b1;
  logic       busy;
  logic [7:0] err_count;
  int checks = 0;
  int errors = 0;

  axis_packet_framer_if s_if();
  axis_packet_framer_if m_if();

  always #5 aclk = ~aclk;

  axis_packet_framer #(.TIMEOUT_CYCLES(TO)) dut (
    .aclk(aclk), .reset(reset), .s_axis(s_if), .m_axis(m_if), .busy(busy), .err_count(err_count)
  );

  typedef struct {
    logic sv; logic [31:0] sd; logic mr;
    logic srdy; logic mv; logic [31:0] md; logic ml; logic [7:0] mu; logic bz; logic [7:0] ec;
  } vec_t;

  typedef struct packed { logic [31:0] d; logic l; logic [7:0] u; } beat_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(logic sv, logic [31:0] sd, logic mr, logic srdy, logic mv,
                              logic [31:0] md, logic ml, logic [7:0] mu, logic bz, logic [7:0] ec);
    vec_t v;
    v.sv = sv; v.sd = sd; v.mr = mr; v.srdy = srdy; v.mv = mv;
    v.md = md; v.ml = ml; v.mu = mu; v.bz = bz; v.ec = ec;
    return v;
  endfunction

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic drive(input logic sv, input logic [31:0] sd, input logic mr);
    s_if.tvalid = sv;
    s_if.tdata  = sd;
    m_if.tready = mr;
  endtask

  vec_t        vt[22];
  logic [31:0] words[$];
  beat_t       exp_q[$];
  beat_t       got_q[$];
  beat_t       held_beat;
  int          exp_err;

  initial begin
    // Cycle table: inputs for one cycle, outputs expected after the following edge.
    vt[0]  = mk(1, 32'h05000003, 1, 1, 0, 0, 0, 8'h00, 1, 0);
    vt[1]  = mk(1, 32'h0000000A, 1, 1, 1, 32'hA, 0, 8'h05, 1, 0);
    vt[2]  = mk(1, 32'h0000000B, 1, 1, 1, 32'hB, 0, 8'h05, 1, 0);
    vt[3]  = mk(1, 32'h0000000C, 1, 1, 1, 32'hC, 1, 8'h05, 0, 0);
    vt[4]  = mk(1, 32'h07000000, 1, 1, 0, 0, 0, 8'h00, 0, 1);
    vt[5]  = mk(1, 32'h07000001, 1, 1, 0, 0, 0, 8'h00, 1, 1);
    vt[6]  = mk(1, 32'h12345678, 1, 1, 1, 32'h12345678, 1, 8'h07, 0, 1);
    vt[7]  = mk(0, 32'h0, 1, 1, 0, 0, 0, 8'h00, 0, 1);
    vt[8]  = mk(1, 32'h11000002, 1, 1, 0, 0, 0, 8'h00, 1, 1);
    vt[9]  = mk(1, 32'h00000100, 1, 1, 1, 32'h100, 0, 8'h11, 1, 1);
    vt[10] = mk(1, 32'h00000101, 1, 1, 1, 32'h101, 1, 8'h11, 0, 1);
    vt[11] = mk(1, 32'h22000001, 1, 1, 0, 0, 0, 8'h00, 1, 1);
    vt[12] = mk(1, 32'h00000200, 1, 1, 1, 32'h200, 1, 8'h22, 0, 1);
    vt[13] = mk(1, 32'h33000002, 1, 1, 0, 0, 0, 8'h00, 1, 1);
    vt[14] = mk(1, 32'h000000AA, 0, 1, 1, 32'hAA, 0, 8'h33, 1, 1);
    vt[15] = mk(1, 32'h000000BB, 0, 0, 1, 32'hAA, 0, 8'h33, 1, 1);
    vt[16] = mk(1, 32'h000000BB, 1, 1, 1, 32'hBB, 1, 8'h33, 0, 1);
    vt[17] = mk(0, 32'h0, 0, 1, 1, 32'hBB, 1, 8'h33, 0, 1);
    vt[18] = mk(1, 32'h44000001, 0, 1, 1, 32'hBB, 1, 8'h33, 1, 1);
    vt[19] = mk(1, 32'h000000CC, 0, 0, 1, 32'hBB, 1, 8'h33, 1, 1);
    vt[20] = mk(1, 32'h000000CC, 1, 1, 1, 32'hCC, 1, 8'h44, 0, 1);
    vt[21] = mk(0, 32'h0, 1, 1, 0, 0, 0, 8'h00, 0, 1);

    s_if.tlast = 1'b0;
    s_if.tuser = 8'h00;
    drive(1'b1, 32'h05000003, 1'b1);
    step();
    step();
    chk("rst_srdy", {31'd0, s_if.tready}, 32'd0);
    chk("rst_mvld", {31'd0, m_if.tvalid}, 32'd0);
    chk("rst_mlast", {31'd0, m_if.tlast}, 32'd0);
    chk("rst_mdata", m_if.tdata, 32'd0);
    chk("rst_muser", {24'd0, m_if.tuser}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_err", {24'd0, err_count}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 22; i++) begin
      drive(vt[i].sv, vt[i].sd, vt[i].mr);
      #1;
      chk($sformatf("v%0d_srdy", i), {31'd0, s_if.tready}, {31'd0, vt[i].srdy});
      step();
      chk($sformatf("v%0d_mvld", i), {31'd0, m_if.tvalid}, {31'd0, vt[i].mv});
      chk($sformatf("v%0d_busy", i), {31'd0, busy}, {31'd0, vt[i].bz});
      chk($sformatf("v%0d_err", i), {24'd0, err_count}, {24'd0, vt[i].ec});
      if (vt[i].mv) begin
        chk($sformatf("v%0d_mdata", i), m_if.tdata, vt[i].md);
        chk($sformatf("v%0d_mlast", i), {31'd0, m_if.tlast}, {31'd0, vt[i].ml});
        chk($sformatf("v%0d_muser", i), {24'd0, m_if.tuser}, {24'd0, vt[i].mu});
      end
    end

    // Zero-length headers: count, then saturation at 255.
    drive(1'b1, 32'h5A000000, 1'b1);
    for (int i = 0; i < 10; i++) step();
    chk("zlen_err11", {24'd0, err_count}, 32'd11);
    chk("zlen_busy", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 250; i++) step();
    chk("zlen_sat", {24'd0, err_count}, 32'd255);

    // Reset in the middle of a 5-word packet.
    drive(1'b1, 32'h09000005, 1'b1); step();
    drive(1'b1, 32'h00000090, 1'b1); step();
    drive(1'b1, 32'h00000091, 1'b1); step();
    chk("mid_mdata", m_if.tdata, 32'h91);
    s_if.tvalid = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_mvld", {31'd0, m_if.tvalid}, 32'd0);
    chk("mid_rst_mlast", {31'd0, m_if.tlast}, 32'd0);
    chk("mid_rst_srdy", {31'd0, s_if.tready}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_err", {24'd0, err_count}, 32'd0);
    step();
    reset = 1'b0;
    drive(1'b1, 32'h01000001, 1'b1); step();
    chk("post_hdr_busy", {31'd0, busy}, 32'd1);
    chk("post_hdr_mvld", {31'd0, m_if.tvalid}, 32'd0);
    drive(1'b1, 32'h00000077, 1'b1); step();
    chk("post_mvld", {31'd0, m_if.tvalid}, 32'd1);
    chk("post_mdata", m_if.tdata, 32'h77);
    chk("post_mlast", {31'd0, m_if.tlast}, 32'd1);
    chk("post_muser", {24'd0, m_if.tuser}, 32'h01);
    drive(1'b0, 32'h0, 1'b1); step();

    // Randomized packets against a parser model of the word stream.
    exp_err = 0;
    for (int p = 0; p < 40; p++) begin
      int          len;
      logic [7:0]  op;
      logic [31:0] w;
      len = $urandom_range(0, 6);
      op  = 8'($urandom);
      words.push_back({op, 8'($urandom), 16'(len)});
      if (len == 0) exp_err++;
      for (int k = 0; k < len; k++) begin
        w = $urandom;
        words.push_back(w);
        exp_q.push_back({w, (k == len - 1), op});
      end
    end
    begin
      int   cyc, idle;
      logic held, stall_pend;
      cyc = 0; idle = 0; held = 1'b0; stall_pend = 1'b0;
      while ((words.size() > 0 || got_q.size() < exp_q.size()) && cyc < 5000) begin
        if (!held) begin
          if (words.size() > 0 && ($urandom_range(0, 1) == 1 || idle >= 3)) begin
            s_if.tvalid = 1'b1;
            s_if.tdata  = words[0];
            held = 1'b1;
            idle = 0;
          end else begin
            s_if.tvalid = 1'b0;
            idle++;
          end
        end
        m_if.tready = 1'($urandom_range(0, 1));
        @(negedge aclk);
        if (stall_pend) begin
          chk("rnd_hold_vld", {31'd0, m_if.tvalid}, 32'd1);
          chk("rnd_hold_beat", 32'({m_if.tdata, m_if.tlast, m_if.tuser} != held_beat), 32'd0);
        end
        if (s_if.tvalid && s_if.tready) begin
          void'(words.pop_front());
          held = 1'b0;
        end
        if (m_if.tvalid && m_if.tready) got_q.push_back({m_if.tdata, m_if.tlast, m_if.tuser});
        stall_pend = m_if.tvalid && !m_if.tready;
        held_beat  = {m_if.tdata, m_if.tlast, m_if.tuser};
        step();
        cyc++;
      end
      chk("rnd_in_budget", {31'd0, cyc < 5000}, 32'd1);
    end
    s_if.tvalid = 1'b0;
    m_if.tready = 1'b1;
    chk("rnd_beat_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk($sformatf("rnd_beat%0d_dat", i), got_q[i].d, exp_q[i].d);
      chk($sformatf("rnd_beat%0d_lu", i), {23'd0, got_q[i].l, got_q[i].u}, {23'd0, exp_q[i].l, exp_q[i].u});
    end
    chk("rnd_err", {24'd0, err_count}, 32'(exp_err));
    step();
    chk("rnd_idle_busy", {31'd0, busy}, 32'd0);

`ifdef AXIS_PACKET_FRAMER_TIMEOUT_EN
    begin
      int n;
      drive(1'b1, 32'h06000003, 1'b1); step();
      drive(1'b1, 32'h00000005, 1'b1); step();
      drive(1'b0, 32'h0, 1'b1);
      n = 0;
      for (int i = 1; i <= 40 && n == 0; i++) begin
        step();
        if (m_if.tvalid && m_if.tlast && m_if.tdata == 32'd0) n = i;
      end
      chk("to_flush_cycle", 32'(n), 32'd17);
      chk("to_flush_user", {24'd0, m_if.tuser}, 32'h06);
      chk("to_err", {24'd0, err_count}, 32'(exp_err + 1));
      chk("to_busy", {31'd0, busy}, 32'd0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
